// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle divider.
// Special-case results are built here so every width gets the same encoding.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } divState_t;

    localparam int MAX_WIDTH = 64;

    typedef struct packed {
        logic [MAX_WIDTH-1:0] quot;
        logic [MAX_WIDTH-1:0] rem;
    } specialResult_t;

    // Overflow gives quotient = -2^(width-1), remainder 0; divide-by-zero gives all ones.
    // The divide-by-zero remainder is the live dividend, so rem is only meaningful for overflow.
    function automatic specialResult_t specialResult(input int unsigned width, input logic isOverflow);
        specialResult_t res;
        res.rem = '0;
        if (isOverflow) begin
            res.quot = {{(MAX_WIDTH-1){1'b0}}, 1'b1} << (width - 1);
        end else begin
            res.quot = {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
        end
        return res;
    endfunction

endpackage

// File: rtl/division_sequencer_ovfdetect.sv
// Flags the one signed operand pair whose quotient does not fit: -2^(width-1) / -1.
module divisionOverflowDetectionBlock #(
    parameter int width = 32
) (
    input  logic [width-1:0] i_dividend,
    input  logic [width-1:0] i_divisor,
    output logic             o_overflow
);

    logic [width-1:0] w_mostNegative;

    assign w_mostNegative = {1'b1, {(width-1){1'b0}}};
    assign o_overflow     = (i_dividend == w_mostNegative) && (i_divisor == {width{1'b1}});

endmodule

// File: rtl/division_sequencer.sv
// Radix-2 restoring divider: special cases resolve at accept, all others
// take width iterations plus one sign-fixup cycle.
module division_sequencer
    import div_pkg::*;
#(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             isSigned,
    input  logic [width-1:0] dividend,
    input  logic [width-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [width-1:0] quotient,
    output logic [width-1:0] remainder,
    output logic             divByZero,
    output logic             overflow
);

    localparam int CW = $clog2(width);
    localparam specialResult_t OVF_RES  = specialResult(width, 1'b1);
    localparam specialResult_t ZERO_RES = specialResult(width, 1'b0);

    divState_t        r_state;
    divState_t        w_nextState;
    logic [CW-1:0]    r_count;
    logic [width:0]   r_partRem;
    logic [width-1:0] r_quoShift;
    logic [width-1:0] r_divisorMag;
    logic             r_negQuo;
    logic             r_negRem;
    logic             r_done;
    logic [width-1:0] r_quotient;
    logic [width-1:0] r_remainder;
    logic             r_divByZero;
    logic             r_overflow;

    logic             w_detOverflow;
    logic             w_overflow;
    logic             w_divZero;
    logic             w_dividendNeg;
    logic             w_divisorNeg;
    logic [width-1:0] w_dividendMag;
    logic [width-1:0] w_divisorMag;
    logic [width+1:0] w_shifted;
    logic [width+1:0] w_trial;
    logic             w_trialOk;

    divisionOverflowDetectionBlock #(
        .width(width)
    ) u_ovfDetect (
        .i_dividend(dividend),
        .i_divisor (divisor),
        .o_overflow(w_detOverflow)
    );

    assign w_overflow    = isSigned && w_detOverflow;
    assign w_divZero     = (divisor == '0);
    assign w_dividendNeg = isSigned && dividend[width-1];
    assign w_divisorNeg  = isSigned && divisor[width-1];
    assign w_dividendMag = w_dividendNeg ? -dividend : dividend;
    assign w_divisorMag  = w_divisorNeg ? -divisor : divisor;

    // Two extra bits above the partial remainder so the trial's sign bit is an exact borrow.
    assign w_shifted = {r_partRem, r_quoShift[width-1]};
    assign w_trial   = w_shifted - {2'b00, r_divisorMag};
    assign w_trialOk = ~w_trial[width+1];

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (start && !w_divZero && !w_overflow) begin
                    w_nextState = ITER;
                end
            end
            ITER: begin
                if (r_count == '0) begin
                    w_nextState = FIX;
                end
            end
            FIX:     w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_partRem    <= '0;
            r_quoShift   <= '0;
            r_divisorMag <= '0;
            r_negQuo     <= 1'b0;
            r_negRem     <= 1'b0;
            r_done       <= 1'b0;
            r_quotient   <= '0;
            r_remainder  <= '0;
            r_divByZero  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_divZero) begin
                            r_quotient  <= ZERO_RES.quot[width-1:0];
                            r_remainder <= dividend;
                            r_divByZero <= 1'b1;
                            r_overflow  <= 1'b0;
                            r_done      <= 1'b1;
                        end else if (w_overflow) begin
                            r_quotient  <= OVF_RES.quot[width-1:0];
                            r_remainder <= OVF_RES.rem[width-1:0];
                            r_divByZero <= 1'b0;
                            r_overflow  <= 1'b1;
                            r_done      <= 1'b1;
                        end else begin
                            // Visible results stay untouched until the fixup edge.
                            r_negRem     <= w_dividendNeg;
                            r_negQuo     <= w_dividendNeg ^ w_divisorNeg;
                            r_quoShift   <= w_dividendMag;
                            r_divisorMag <= w_divisorMag;
                            r_partRem    <= '0;
                            r_count      <= CW'(width - 1);
                        end
                    end
                end
                ITER: begin
                    r_partRem  <= w_trialOk ? w_trial[width:0] : w_shifted[width:0];
                    r_quoShift <= {r_quoShift[width-2:0], w_trialOk};
                    r_count    <= r_count - CW'(1);
                end
                FIX: begin
                    r_quotient  <= r_negQuo ? -r_quoShift : r_quoShift;
                    r_remainder <= r_negRem ? -r_partRem[width-1:0] : r_partRem[width-1:0];
                    r_divByZero <= 1'b0;
                    r_overflow  <= 1'b0;
                    r_done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ready     = (r_state == IDLE);
    assign done      = r_done;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign divByZero = r_divByZero;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_division_sequencer.sv
// Directed and random checks of division_sequencer against a plain-arithmetic
// reference of truncating signed/unsigned division.
module tb_division_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         isSigned;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         ready;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         divByZero;
    logic         overflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    division_sequencer #(.width(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .isSigned (isSigned),
        .dividend (dividend),
        .divisor  (divisor),
        .ready    (ready),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder),
        .divByZero(divByZero),
        .overflow (overflow)
    );

    task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Latency counts the accepting edge as 1, so a special case reads 1 and a normal op W+2.
    function automatic void refModel(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] q, output logic [W-1:0] r,
                                     output logic dz, output logic ov, output int lat);
        longint sa;
        longint sb;
        dz  = 1'b0;
        ov  = 1'b0;
        lat = W + 2;
        if (b == '0) begin
            q   = '1;
            r   = a;
            dz  = 1'b1;
            lat = 1;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q   = a;
            r   = '0;
            ov  = 1'b1;
            lat = 1;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic applyStimulus(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start    = 1'b1;
        isSigned = sgn;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        isSigned = 1'($urandom_range(0, 1));
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    task automatic waitDone(input int startLat, output int lat);
        lat = startLat;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic runAndCheck(input string tag, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        int lat;
        int elat;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic edz;
        logic eov;
        refModel(sgn, a, b, eq, er, edz, eov, elat);
        applyStimulus(sgn, a, b);
        waitDone(1, lat);
        checkOutput({tag, ".lat"}, W'(lat), W'(elat));
        checkOutput({tag, ".q"}, quotient, eq);
        checkOutput({tag, ".r"}, remainder, er);
        checkOutput({tag, ".dz"}, W'(divByZero), W'(edz));
        checkOutput({tag, ".ov"}, W'(overflow), W'(eov));
        checkOutput({tag, ".rdy"}, W'(ready), W'(1));
    endtask

    initial begin
        int lat;
        int elat;
        int heldErr;
        int pulses;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic [W-1:0] aq;
        logic [W-1:0] ar;
        logic edz;
        logic eov;
        logic sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;

        rst_n    = 1'b0;
        start    = 1'b0;
        isSigned = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst.ready", W'(ready), W'(1));
        checkOutput("rst.done", W'(done), W'(0));
        checkOutput("rst.q", quotient, '0);
        checkOutput("rst.r", remainder, '0);
        checkOutput("rst.dz", W'(divByZero), W'(0));
        checkOutput("rst.ov", W'(overflow), W'(0));
        @(negedge clk);
        rst_n = 1'b1;

        runAndCheck("s7div2", 1'b1, 32'd7, 32'd2);
        runAndCheck("sm7div2", 1'b1, -32'sd7, 32'd2);
        runAndCheck("sovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        runAndCheck("s0div", 1'b1, 32'h1234_5678, 32'd0);
        runAndCheck("u0div", 1'b0, 32'h1234_5678, 32'd0);
        runAndCheck("uovfpair", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);

        // A start while busy must be dropped, not queued; divisor 0 would show up immediately.
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1);
        lat = 1;
        repeat (5) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("busy.ready", W'(ready), W'(0));
        checkOutput("busy.heldQ", quotient, 32'd0);
        checkOutput("busy.heldR", remainder, 32'h8000_0000);
        @(negedge clk);
        start    = 1'b1;
        isSigned = 1'b1;
        dividend = 32'd5;
        divisor  = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat++;
        checkOutput("busy.noDz", W'(divByZero), W'(0));
        waitDone(lat, lat);
        checkOutput("busy.lat", W'(lat), W'(W + 2));
        checkOutput("busy.q", quotient, 32'hFFFF_FFFF);
        checkOutput("busy.r", remainder, 32'd0);
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        checkOutput("busy.noQueue", W'(pulses), W'(0));

        // Reset lands on the tenth edge after accept.
        applyStimulus(1'b1, 32'h0765_4321, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midrst.ready", W'(ready), W'(1));
        checkOutput("midrst.done", W'(done), W'(0));
        checkOutput("midrst.q", quotient, '0);
        checkOutput("midrst.r", remainder, '0);
        checkOutput("midrst.flags", W'({divByZero, overflow}), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        checkOutput("midrst.noDone", W'(pulses), W'(0));
        runAndCheck("u100div7", 1'b0, 32'd100, 32'd7);

        // Second start issued in the done cycle of the first.
        runAndCheck("b2bA", 1'b1, 32'd1000, -32'sd7);
        refModel(1'b1, 32'd1000, -32'sd7, aq, ar, edz, eov, elat);
        refModel(1'b0, 32'hDEAD_BEEF, 32'h0000_1234, eq, er, edz, eov, elat);
        start    = 1'b1;
        isSigned = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h0000_1234;
        @(posedge clk);
        #1;
        start   = 1'b0;
        lat     = 1;
        heldErr = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (quotient !== aq || remainder !== ar) heldErr++;
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("b2b.held", W'(heldErr), W'(0));
        checkOutput("b2b.lat", W'(lat), W'(elat));
        checkOutput("b2b.q", quotient, eq);
        checkOutput("b2b.r", remainder, er);

        for (int i = 0; i < 40; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 9))
                0:       b = '0;
                1: begin
                    a   = 32'h8000_0000;
                    b   = 32'hFFFF_FFFF;
                end
                2:       b = W'($urandom_range(1, 15));
                3:       b = -W'($urandom_range(1, 15));
                4:       b = a;
                default: b = $urandom;
            endcase
            runAndCheck($sformatf("rnd%0d", i), sgn, a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
